// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, instruction field positions and fetch FSM states.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_LSB = 25;

  typedef enum logic [0:0] {
    StRun,
    StFault
  } fetch_state_e;

  function automatic logic is_aligned(input logic [31:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_rv32i_if.sv
// Instruction-memory request/response bus plus the decoded-instruction stream to decode.
interface fetch_unit_rv32i_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output id_valid, id_pc, id_instr, id_opcode, id_funct3, id_funct7, id_rd, id_rs1, id_rs2,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  id_valid, id_pc, id_instr, id_opcode, id_funct3, id_funct7, id_rd, id_rs1, id_rs2,
    output id_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head read and a synchronous flush.
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty;
  // Push into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush_i && !reset) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit_rv32i.sv
// RV32I fetch stage: owns the PC, issues word reads, buffers responses and presents them to
// decode with pre-split fields. Redirects flush buffered work and drop in-flight responses.
module fetch_unit_rv32i
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  fetch_unit_rv32i_if.master        bus,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      fetch_fault
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned SumW = CntW + 1;

  fetch_state_e    state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW-1:0] count, pend_count;

  logic            run, req, grant, resp, keep, valid, pop;
  logic [31:0]     pend_pc;
  logic [63:0]     head;
  logic [31:0]     instr;

  assign run   = (state_q == StRun);
  // Only registered occupancy feeds the request, so id_ready never reaches imem_req.
  assign req   = ~reset & run &
                 (({1'b0, inflight_q} + {1'b0, count}) < SumW'(DEPTH));
  assign grant = req & bus.imem_gnt;
  assign resp  = bus.imem_rvalid & (inflight_q != '0);
  assign keep  = resp & (drop_q == '0) & ~redirect_valid & (pend_count != '0);
  assign valid = run & (count != '0);
  assign pop   = valid & bus.id_ready & ~redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;

    if (grant) begin
      inflight_d = inflight_d + CntW'(1);
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (resp) begin
      inflight_d = inflight_d - CntW'(1);
      if (drop_q != '0) drop_d = drop_q - CntW'(1);
    end

    // Everything still outstanding, including this cycle's grant, belongs to the old stream.
    if (redirect_valid) begin
      drop_d     = inflight_d;
      fetch_pc_d = redirect_pc;
      state_d    = is_aligned(redirect_pc) ? StRun : StFault;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // PCs of requests that will be kept, recorded at grant time in request order.
  sync_fifo #(
    .Width (32),
    .Depth (DEPTH)
  ) u_pc_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (grant & ~redirect_valid),
    .wdata_i (fetch_pc_q),
    .pop_i   (keep),
    .rdata_o (pend_pc),
    .count_o (pend_count)
  );

  sync_fifo #(
    .Width (64),
    .Depth (DEPTH)
  ) u_instr_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (keep),
    .wdata_i ({pend_pc, bus.imem_rdata}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  assign instr = valid ? head[31:0] : 32'h0;

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.id_valid  = valid;
  assign bus.id_pc     = valid ? head[63:32] : 32'h0;
  assign bus.id_instr  = instr;
  assign bus.id_opcode = instr[OPCODE_LSB +: 7];
  assign bus.id_rd     = instr[RD_LSB +: 5];
  assign bus.id_funct3 = instr[FUNCT3_LSB +: 3];
  assign bus.id_rs1    = instr[RS1_LSB +: 5];
  assign bus.id_rs2    = instr[RS2_LSB +: 5];
  assign bus.id_funct7 = instr[FUNCT7_LSB +: 7];

  assign fetch_fault = (state_q == StFault);

endmodule

// File: tb/tb_fetch_unit_rv32i.sv
// Directed bench for fetch_unit_rv32i with an in-order memory model and a PC scoreboard.
module tb_fetch_unit_rv32i;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_fault;
  logic        gnt = 1'b0, rvalid = 1'b0, id_ready = 1'b0;
  logic [31:0] rdata = 32'h0;

  fetch_unit_rv32i_if bus();

  assign bus.imem_gnt    = gnt;
  assign bus.imem_rvalid = rvalid;
  assign bus.imem_rdata  = rdata;
  assign bus.id_ready    = id_ready;

  fetch_unit_rv32i #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  int          cyc = 0, last_due = 0;
  int          n_cmp = 0, n_err = 0;
  int          n_gnt = 0, pop_cnt = 0;
  int          lat_min = 1, lat_max = 1;
  logic        gnt_rand = 1'b0;
  logic [31:0] exp_pc = 32'h0, exp_gaddr = 32'h0, last_pop_pc = 32'h0, prev_addr = 32'h0;
  logic        prev_wait = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[31:7] ^ 25'h1A5_A5A5, 7'h13};
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_pop(input int target, input int budget, input string tag);
    int k = 0;
    while (pop_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(pop_cnt >= target), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Memory model drive: grant and in-order responses, changed just after the edge.
  always @(posedge clock) begin
    #1;
    gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!reset && pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
      rvalid = 1'b1;
      rdata  = instr_at(pend_q[0].addr);
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
  end

  // Monitor: records grants, consumes responses and scoreboards decode pops.
  always @(negedge clock) begin
    if (reset) begin
      pend_q.delete();
      last_due  = 0;
      exp_pc    = 32'h0;
      exp_gaddr = 32'h0;
      prev_wait = 1'b0;
    end else begin
      if (bus.imem_req && prev_wait) check_eq("addr_hold", bus.imem_addr, prev_addr);
      if (bus.imem_req && bus.imem_gnt) begin
        int due;
        check_eq("grant_addr", bus.imem_addr, exp_gaddr);
        exp_gaddr = exp_gaddr + 32'd4;
        n_gnt++;
        due = cyc + 1 + $urandom_range(lat_min, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_q.push_back('{addr: bus.imem_addr, due: due});
      end
      if (bus.imem_rvalid && pend_q.size() > 0) void'(pend_q.pop_front());
      if (bus.id_valid && id_ready && !redirect_valid) begin
        check_eq("pop_pc", bus.id_pc, exp_pc);
        check_eq("pop_instr", bus.id_instr, instr_at(exp_pc));
        exp_pc      = exp_pc + 32'd4;
        last_pop_pc = bus.id_pc;
        pop_cnt++;
      end
      if (redirect_valid) begin
        exp_pc    = redirect_pc;
        exp_gaddr = redirect_pc;
      end
      prev_wait = bus.imem_req && !bus.imem_gnt && !redirect_valid;
      prev_addr = bus.imem_addr;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, p0;
    logic hit;
    id_ready = 1'b1;
    repeat (3) tick();

    check_eq("rst_req",   32'(bus.imem_req), 32'd0);
    check_eq("rst_valid", 32'(bus.id_valid), 32'd0);
    check_eq("rst_fault", 32'(fetch_fault),  32'd0);
    check_eq("rst_addr",  bus.imem_addr,     32'h0);
    check_eq("rst_pc",    bus.id_pc,         32'h0);
    check_eq("rst_instr", bus.id_instr,      32'h0);

    reset = 1'b0;
    #1;
    check_eq("first_req",  32'(bus.imem_req), 32'd1);
    check_eq("first_addr", bus.imem_addr,     32'h0);
    tick();
    check_eq("lat_not_yet", 32'(bus.id_valid), 32'd0);
    tick();
    check_eq("lat_valid",  32'(bus.id_valid),  32'd1);
    check_eq("first_pc",   bus.id_pc,          32'h0);
    check_eq("first_op",   32'(bus.id_opcode), 32'h13);
    check_eq("first_rd",   32'(bus.id_rd),     32'd1);
    check_eq("first_f3",   32'(bus.id_funct3), 32'd0);
    check_eq("first_rs1",  32'(bus.id_rs1),    32'd0);
    check_eq("first_rs2",  32'(bus.id_rs2),    32'd5);
    check_eq("first_f7",   32'(bus.id_funct7), 32'd0);
    repeat (10) tick();

    // Decode stall: requests must stop once buffer plus in-flight reach DEPTH.
    id_ready = 1'b0;
    n0 = n_gnt;
    repeat (10) tick();
    check_eq("stall_grants", 32'((n_gnt - n0) <= 2), 32'd1);
    check_eq("stall_req",    32'(bus.imem_req),      32'd0);
    check_eq("stall_full",   32'(bus.id_valid),      32'd1);
    id_ready = 1'b1;
    p0 = pop_cnt;
    repeat (20) tick();
    check_eq("resume_pops", 32'((pop_cnt - p0) >= 5), 32'd1);

    // Redirect with two requests outstanding.
    lat_min = 4;
    lat_max = 4;
    repeat (4) tick();
    for (int k = 0; k < 20 && pend_q.size() != 2; k++) tick();
    check_eq("two_inflight", 32'(pend_q.size()), 32'd2);
    p0 = pop_cnt;
    do_redirect(32'h100);
    check_eq("redir_flush", 32'(bus.id_valid), 32'd0);
    wait_pop(p0 + 1, 40, "redir_pop_seen");
    check_eq("redir_pc", last_pop_pc, 32'h100);

    // Redirect coinciding with a grant and a response.
    lat_min = 1;
    lat_max = 1;
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      tick();
      hit = bus.imem_req && bus.imem_gnt && bus.imem_rvalid;
    end
    check_eq("same_cycle_found", 32'(hit), 32'd1);
    p0 = pop_cnt;
    do_redirect(32'h400);
    wait_pop(p0 + 1, 40, "same_pop_seen");
    check_eq("same_pc", last_pop_pc, 32'h400);
    repeat (6) tick();

    // Misaligned target parks the unit in FAULT until an aligned redirect.
    do_redirect(32'h102);
    check_eq("fault_flag",  32'(fetch_fault),  32'd1);
    check_eq("fault_req",   32'(bus.imem_req), 32'd0);
    check_eq("fault_valid", 32'(bus.id_valid), 32'd0);
    repeat (6) tick();
    check_eq("fault_hold",     32'(fetch_fault),  32'd1);
    check_eq("fault_hold_req", 32'(bus.imem_req), 32'd0);
    p0 = pop_cnt;
    do_redirect(32'h200);
    check_eq("fault_clear", 32'(fetch_fault), 32'd0);
    wait_pop(p0 + 1, 40, "resume_pop_seen");
    check_eq("resume_pc", last_pop_pc, 32'h200);

    // Random grants, latencies and decode stalls.
    gnt_rand = 1'b1;
    lat_min  = 1;
    lat_max  = 4;
    p0 = pop_cnt;
    for (int k = 0; k < 300; k++) begin
      tick();
      id_ready = ($urandom_range(0, 3) != 0);
    end
    check_eq("rand_pops", 32'((pop_cnt - p0) > 30), 32'd1);

    // Reset mid-stream discards everything and restarts at RESET_PC.
    reset = 1'b1;
    repeat (2) tick();
    check_eq("mid_rst_valid", 32'(bus.id_valid), 32'd0);
    gnt_rand = 1'b0;
    lat_min  = 1;
    lat_max  = 1;
    id_ready = 1'b1;
    p0 = pop_cnt;
    reset = 1'b0;
    wait_pop(p0 + 1, 20, "mid_rst_pop_seen");
    check_eq("mid_rst_pc", last_pop_pc, 32'h0);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
